// File: rtl/calc_sequencer.sv
// Parametrised calculator sequencer: loads NUM_OPS operands, latches a mode, then chains
// the ALU pairwise into ACC. Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer #(
  parameter int ADDR_W    = 3,
  parameter int NUM_OPS   = 2,
  parameter int MS_W      = 3,
  parameter int NUM_MODES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              go,
  input  logic              next,
  input  logic [MS_W-1:0]   ms,
  input  logic              alu_done,
  output logic [ADDR_W-1:0] num_r1,
  output logic [ADDR_W-1:0] num_r2,
  output logic [ADDR_W-1:0] w1,
  output logic              we,
  output logic [MS_W-1:0]   ms_out,
  output logic [3:0]        cs_out,
  output logic              busy,
  output logic              done_out,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_WAIT = 4'd2,
    S_EXEC = 4'd3,
    S_WB   = 4'd4,
    S_DONE = 4'd5,
    S_ERR  = 4'd6
  } state_t;

  localparam logic [ADDR_W-1:0] ACC  = ADDR_W'(NUM_OPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OPS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [MS_W:0]     MAXM = (MS_W+1)'(NUM_MODES);

  state_t              r_state, w_ns;
  logic [ADDR_W-1:0]   r_idx, w_idx;
  logic [ADDR_W-1:0]   r_step, w_step;
  logic [MS_W-1:0]     r_ms_q, w_msq;
  logic                r_next_q;
  logic                w_lwe;
  logic                w_nxt_p;
  logic                w_ms_ok;

  logic [ADDR_W-1:0]   r_num_r1, r_num_r2, r_w1;
  logic                r_we, r_busy, r_done, r_err;
  logic [MS_W-1:0]     r_ms_out;

`ifdef CALC_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tcnt, w_tcnt;
`endif

  assign w_nxt_p = next & ~r_next_q;
  assign w_ms_ok = (ms != '0) && ({1'b0, ms} <= MAXM);

  // Next-state / datapath update; outputs are decoded from these and registered below.
  always_comb begin
    w_ns   = r_state;
    w_idx  = r_idx;
    w_step = r_step;
    w_msq  = r_ms_q;
    w_lwe  = 1'b0;
`ifdef CALC_TIMEOUT_EN
    w_tcnt = r_tcnt;
`endif
    case (r_state)
      S_IDLE: if (go) begin
        w_ns  = S_LOAD;
        w_idx = '0;
      end
      S_LOAD: begin
        // r_we high means this is the write cycle for RF[idx]
        if (r_we) begin
          if (r_idx == LAST) begin
            w_ns   = S_WAIT;
            w_step = '0;
          end else begin
            w_idx = r_idx + ONE;
          end
        end else if (w_nxt_p) begin
          w_lwe = 1'b1;
        end
      end
      S_WAIT: if (w_nxt_p) begin
        if (w_ms_ok) begin
          w_msq  = ms;
          w_step = ONE;
          w_ns   = S_EXEC;
        end else begin
          w_ns = S_ERR;
        end
      end
      S_EXEC: begin
        if (alu_done) w_ns = S_WB;
`ifdef CALC_TIMEOUT_EN
        else if (r_tcnt == TLIM) w_ns = S_ERR;
        else w_tcnt = r_tcnt + 1'b1;
`endif
      end
      S_WB: begin
        if (r_step == LAST) begin
          w_ns = S_DONE;
        end else begin
          w_step = r_step + ONE;
          w_ns   = S_EXEC;
        end
      end
      S_DONE, S_ERR: if (w_nxt_p) w_ns = S_IDLE;
      default: w_ns = S_IDLE;
    endcase
`ifdef CALC_TIMEOUT_EN
    if (w_ns == S_EXEC && r_state != S_EXEC) w_tcnt = '0;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_step   <= '0;
      r_ms_q   <= '0;
      r_next_q <= 1'b0;
      r_num_r1 <= '1;
      r_num_r2 <= '1;
      r_w1     <= '1;
      r_we     <= 1'b0;
      r_ms_out <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b1;
      r_err    <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      r_tcnt   <= '0;
`endif
    end else begin
      r_state  <= w_ns;
      r_idx    <= w_idx;
      r_step   <= w_step;
      r_ms_q   <= w_msq;
      r_next_q <= next;
`ifdef CALC_TIMEOUT_EN
      r_tcnt   <= w_tcnt;
`endif
      r_num_r1 <= '1;
      r_num_r2 <= '1;
      r_w1     <= '1;
      r_we     <= 1'b0;
      r_ms_out <= '0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (w_ns)
        S_LOAD: begin
          r_num_r1 <= w_idx;
          r_w1     <= w_idx;
          r_we     <= w_lwe;
        end
        S_WAIT: begin
          r_num_r1 <= '0;
          r_num_r2 <= ONE;
        end
        S_EXEC, S_WB: begin
          // first step reads RF[0],RF[1]; later steps chain the accumulator
          r_num_r1 <= (w_step == ONE) ? '0 : ACC;
          r_num_r2 <= w_step;
          r_w1     <= ACC;
          r_ms_out <= w_msq;
          r_we     <= (w_ns == S_WB);
        end
        S_DONE: begin
          r_num_r1 <= ACC;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        S_ERR: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      endcase
    end
  end

  assign num_r1   = r_num_r1;
  assign num_r2   = r_num_r2;
  assign w1       = r_w1;
  assign we       = r_we;
  assign ms_out   = r_ms_out;
  assign cs_out   = r_state;
  assign busy     = r_busy;
  assign done_out = r_done;
  assign err      = r_err;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Parametrised successor to the two-operand calculator control FSM.
- Sequences N operand loads into the register file, latches a mode select, then chains the ALU pairwise across all operands: acc = op(RF[0],RF[1]), then acc = op(acc,RF[k]) for k = 2..N-1.
- Handshakes with a multi-cycle ALU via alu_done.
- Drives register-file addresses and write enable, ALU mode, and the state/LED outputs.

Parameters:
ADDR_W, 3, register-file address width; requires 2^ADDR_W > NUM_OPS
NUM_OPS, 2, operand count N (2..2^ADDR_W-1); accumulator register ACC = NUM_OPS
MS_W, 3, width of mode select
NUM_MODES, 4, legal modes are 1..NUM_MODES (1 add, 2 sub, 3 mul, 4 xor, others ALU-defined)
TIMEOUT, 255, ALU wait limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
go  in  1  start, level-sampled in IDLE only
next  in  1  advance button; internally rising-edge detected (nxt_p = next & ~next_q)
ms  in  MS_W  mode select, sampled on nxt_p in WAIT_MS
alu_done  in  1  ALU result valid, level
num_r1  out  ADDR_W  RF read address port 1
num_r2  out  ADDR_W  RF read address port 2
w1  out  ADDR_W  RF write address
we  out  1  RF write enable
ms_out  out  MS_W  ALU mode
cs_out  out  4  current state code
busy  out  1  high in LOAD, WAIT_MS, EXEC, WB
done_out  out  1  high in IDLE, DONE, ERR
err  out  1  high in ERR only

Behaviour:
- All outputs registered. Reset values: num_r1/num_r2/w1 all ones, we=0, ms_out=0, cs_out=0, busy=0, done_out=1, err=0, idx=0, step=0, next_q=0.
- Reset asserted mid-operation returns to IDLE immediately; no write is issued.
- State codes (cs_out): IDLE=0, LOAD=1, WAIT_MS=2, EXEC=3, WB=4, DONE=5, ERR=6. Codes 7..15 are unreachable and recover to IDLE on the next clock.

IDLE:
- If go=1 on a clock edge: go to LOAD with idx=0.
- go is ignored in all other states.

LOAD:
- num_r1=idx, num_r2=all ones, w1=idx.
- Each nxt_p: we=1 for exactly one cycle, on the cycle after the edge is sampled; RF[idx] captures Din; then idx increments.
- After the write of idx=NUM_OPS-1: go to WAIT_MS.
- If next is held high, only one write occurs.

WAIT_MS:
- num_r1=0, num_r2=1, we=0.
- On nxt_p with 1 <= ms <= NUM_MODES: latch ms_q=ms, step=1, go to EXEC.
- On nxt_p with any other ms (including 0): go to ERR.
- Without nxt_p: stay in WAIT_MS.

EXEC:
- ms_out=ms_q, num_r1 = (step==1) ? 0 : ACC, num_r2=step, we=0.
- Wait for alu_done=1, then go to WB.
- nxt_p is ignored.

WB:
- One cycle: we=1, w1=ACC, ms_out still ms_q (ALU inputs and result held stable).
- If step==NUM_OPS-1: go to DONE.
- Otherwise: step increments and return to EXEC.
- Total writes to ACC equal NUM_OPS-1.

DONE:
- num_r1=ACC (result display), ms_out=0, done_out=1.
- nxt_p: go to IDLE.

ERR:
- err=1, done_out=1, we=0, ms_out=0.
- nxt_p: go to IDLE.

Boundary rules:
- nxt_p coinciding with alu_done in EXEC is ignored.
- A ms change after latching has no effect.
- idx and step never wrap: they are cleared on entry to LOAD and WAIT_MS respectively.

Optional Feature:
Macro CALC_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on EXEC entry and increments each EXEC cycle with alu_done=0. When it reaches TIMEOUT, go to ERR (err=1) and issue no WB write. alu_done in the same cycle as the limit wins (go to WB).
- Undefined: EXEC waits indefinitely; counter logic is absent; ERR is reachable only through an illegal mode.

Test Plan (NUM_OPS=3, ADDR_W=3, ACC=3):
- Reset, go=1, three next pulses -> we single-cycle pulses with w1=0,1,2; cs_out 0->1->2.
- WAIT_MS, ms=1, nxt_p, alu_done returned 2 cycles after each EXEC entry -> EXEC reads (0,1), WB w1=3, EXEC reads (3,2), WB w1=3, then DONE with done_out=1, num_r1=3.
- WAIT_MS with ms=0 and ms=5 -> ERR, err=1, no we; a following nxt_p -> IDLE, cs_out=0.
- Hold next high for 20 cycles in LOAD -> exactly one write (w1=0), idx=1.
- Drop RST_N during the second EXEC -> outputs at reset values asynchronously, cs_out=0, no further we.
- With CALC_TIMEOUT_EN and TIMEOUT=10: alu_done held low -> ERR after 10 EXEC cycles; with alu_done on cycle 10 -> WB taken.
